// File: rtl/blur_pkg.sv
// Shared widths and helpers for the horizontal box-blur stream filter.
package blur_pkg;

  localparam int unsigned PixW     = 8;
  localparam int unsigned TapsDef  = 8;

  // Window length is a power of two, so its log2 is the rounding shift.
  function automatic int unsigned taps_log2(input int unsigned taps);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      if ((32'd1 << i) < taps) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned SumW = PixW + taps_log2(TapsDef);

  typedef logic [PixW-1:0] pix_t;
  typedef logic [SumW-1:0] sum_t;

endpackage

// File: rtl/hblur_chan.sv
// One colour channel: window shift register, running sum and rounded divide.
module hblur_chan
  import blur_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned TAPS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_shift_en,
  input  logic          i_sol,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_y
);

  localparam int unsigned LG = taps_log2(TAPS);
  localparam int unsigned SW = DW + LG;

  // r_win[0] is the newest held pixel, r_win[TAPS-2] the oldest.
  logic [DW-1:0] r_win [TAPS-1];
  logic [SW-1:0] r_sum;

  logic [SW-1:0] w_x_ext;
  logic [SW-1:0] w_old_ext;
  logic [SW-1:0] w_rep;
  logic [SW-1:0] w_roll;
  logic [SW-1:0] w_acc;

  assign w_x_ext   = {{LG{1'b0}}, i_x};
  assign w_old_ext = {{LG{1'b0}}, r_win[TAPS-2]};
  assign w_rep     = (w_x_ext << LG) - w_x_ext;
  assign w_roll    = r_sum + w_x_ext - w_old_ext;
  // Cannot overflow SW: TAPS full-scale values plus TAPS/2 stays below 2^SW.
  assign w_acc     = r_sum + w_x_ext + SW'(TAPS / 2);
  assign o_y       = i_sol ? i_x : w_acc[SW-1:LG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      for (int i = 0; i < int'(TAPS) - 1; i++) r_win[i] <= '0;
    end else if (i_shift_en) begin
      if (i_sol) begin
        r_sum <= w_rep;
        for (int i = 0; i < int'(TAPS) - 1; i++) r_win[i] <= i_x;
      end else begin
        r_sum    <= w_roll;
        r_win[0] <= i_x;
        for (int i = 1; i < int'(TAPS) - 1; i++) r_win[i] <= r_win[i-1];
      end
    end
  end

endmodule

// File: rtl/hblur_stream.sv
// Valid/ready horizontal box-blur with per-beat bypass and constant alpha field.
module hblur_stream
  import blur_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned CH        = 3,
  parameter int unsigned TAPS      = 8,
  parameter int unsigned ALPHA_W   = 8,
  parameter int unsigned ALPHA_VAL = 32'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blur_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sol,
  input  logic [CH*DW-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sol,
  output logic [ALPHA_W+CH*DW-1:0]  out_data
);

  logic               r_valid;
  logic               r_sol;
  logic [CH*DW-1:0]   r_data;

  logic               w_acc;
  logic               w_shift_en;
  logic [CH*DW-1:0]   w_blur;
  logic [CH*DW-1:0]   w_res;

  assign in_ready   = !r_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_shift_en = w_acc && blur_en;
  assign w_res      = blur_en ? w_blur : in_data;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    hblur_chan #(
      .DW   (DW),
      .TAPS (TAPS)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_shift_en (w_shift_en),
      .i_sol      (in_sol),
      .i_x        (in_data[c*DW +: DW]),
      .o_y        (w_blur[c*DW +: DW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_data  <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_sol   <= in_sol;
      r_data  <= w_res;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sol   = r_sol;

  if (ALPHA_W > 0) begin : g_alpha
    localparam logic [ALPHA_W-1:0] AlphaField = ALPHA_W'(ALPHA_VAL);
    assign out_data = {AlphaField, r_data};
  end else begin : g_no_alpha
    assign out_data = r_data;
  end

endmodule
